// File: rtl/sprite_sched_if.sv
// Sprite-update request channel: requester (master) drives slot contents, scheduler (slave) returns ready.
// Optional macro SPRITE_HFLIP_EN adds the per-slot horizontal-flip bit.
interface sprite_sched_if #(
  parameter int NSPR = 4
);
  localparam int IDW = (NSPR > 1) ? $clog2(NSPR) : 1;

  logic           upd_valid;
  logic           upd_ready;
  logic [IDW-1:0] upd_id;
  logic [9:0]     upd_x;
  logic [9:0]     upd_y;
  logic [3:0]     upd_tile;
  logic           upd_en;
`ifdef SPRITE_HFLIP_EN
  logic           upd_flip;

  modport master (output upd_valid, upd_id, upd_x, upd_y, upd_tile, upd_en, upd_flip,
                  input  upd_ready);
  modport slave  (input  upd_valid, upd_id, upd_x, upd_y, upd_tile, upd_en, upd_flip,
                  output upd_ready);
`else
  modport master (output upd_valid, upd_id, upd_x, upd_y, upd_tile, upd_en,
                  input  upd_ready);
  modport slave  (input  upd_valid, upd_id, upd_x, upd_y, upd_tile, upd_en,
                  output upd_ready);
`endif
endinterface

// File: rtl/sprite_sched.sv
// Double-buffered sprite scheduler: hit-tests the raster against NSPR slots and fetches the winner's ROM pixel.
// Optional macro SPRITE_HFLIP_EN enables per-slot horizontal flip.
module sprite_sched #(
  parameter int DATA_WIDTH = 24,
  parameter int NSPR       = 4,
  parameter int SPR_LOG2   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              i_hcount,
  input  logic [9:0]              i_vcount,
  input  logic                    i_bright,
  sprite_sched_if.slave           upd,
  output logic [3+2*SPR_LOG2:0]   o_rom_addr,
  input  logic [DATA_WIDTH-1:0]   i_rom_data,
  output logic [DATA_WIDTH-1:0]   o_pixel,
  output logic                    o_pix_en,
  output logic [9:0]              o_hcount,
  output logic [9:0]              o_vcount,
  output logic                    o_bright,
  output logic                    o_frame_commit
);
  localparam int IDW  = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam int AW   = 4 + 2*SPR_LOG2;
  localparam int SIDE = 2**SPR_LOG2;

  localparam logic [1:0] WAIT_FIRST = 2'd0;
  localparam logic [1:0] RUN        = 2'd1;
  localparam logic [1:0] COMMIT     = 2'd2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] tile;
    logic       en;
`ifdef SPRITE_HFLIP_EN
    logic       flip;
`endif
  } slot_t;

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic                    w_upd_ready;
  logic                    w_upd_fire;
  slot_t                   w_upd_slot;
  logic [NSPR-1:0]         w_hit;
  logic [NSPR-1:0][AW-1:0] w_addr;
  logic                    w_any;
  logic [AW-1:0]           w_sel_addr;

  logic [AW-1:0]           r_rom_addr;
  logic                    r_hit1;
  logic [9:0]              r_h1, r_v1, r_h2, r_v2;
  logic                    r_b1, r_b2;
  logic                    r_pix_en;

  assign w_upd_ready = (r_state != COMMIT);
  assign w_upd_fire  = upd.upd_valid && w_upd_ready;
  assign upd.upd_ready = w_upd_ready;

  always_comb begin
    w_upd_slot      = '0;
    w_upd_slot.x    = upd.upd_x;
    w_upd_slot.y    = upd.upd_y;
    w_upd_slot.tile = upd.upd_tile;
    w_upd_slot.en   = upd.upd_en;
`ifdef SPRITE_HFLIP_EN
    w_upd_slot.flip = upd.upd_flip;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_FIRST, RUN: if (i_vcount == 10'd480 && i_hcount == 10'd0) w_state_next = COMMIT;
      COMMIT:          w_state_next = RUN;
      default:         w_state_next = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WAIT_FIRST;
    else        r_state <= w_state_next;
  end

  for (genvar gi = 0; gi < NSPR; gi++) begin : g_slot
    slot_t       r_stg;
    slot_t       r_act;
    logic [10:0] w_dx, w_dy;
    logic [SPR_LOG2-1:0] w_col;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_stg <= '0;
        r_act <= '0;
      end else begin
        if (w_upd_fire && upd.upd_id == IDW'(gi)) r_stg <= w_upd_slot;
        if (r_state == COMMIT) r_act <= r_stg;
      end
    end

    // 11-bit subtraction: a sprite near x=1023 must not wrap back onto column 0.
    assign w_dx = {1'b0, i_hcount} - {1'b0, r_act.x};
    assign w_dy = {1'b0, i_vcount} - {1'b0, r_act.y};
    assign w_hit[gi] = r_act.en
                    && ({1'b0, i_hcount} >= {1'b0, r_act.x}) && (w_dx < 11'(SIDE))
                    && ({1'b0, i_vcount} >= {1'b0, r_act.y}) && (w_dy < 11'(SIDE));
`ifdef SPRITE_HFLIP_EN
    assign w_col = r_act.flip ? ~w_dx[SPR_LOG2-1:0] : w_dx[SPR_LOG2-1:0];
`else
    assign w_col = w_dx[SPR_LOG2-1:0];
`endif
    assign w_addr[gi] = {r_act.tile, w_dy[SPR_LOG2-1:0], w_col};
  end

  // Walk from the top slot down so the lowest-index hit is the last assignment.
  always_comb begin
    w_any      = 1'b0;
    w_sel_addr = '0;
    for (int i = NSPR-1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any      = 1'b1;
        w_sel_addr = w_addr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_h1       <= '0;
      r_v1       <= '0;
      r_b1       <= 1'b0;
      r_pix_en   <= 1'b0;
      r_h2       <= '0;
      r_v2       <= '0;
      r_b2       <= 1'b0;
    end else begin
      r_rom_addr <= w_sel_addr;
      r_hit1     <= w_any && i_bright && (r_state != WAIT_FIRST);
      r_h1       <= i_hcount;
      r_v1       <= i_vcount;
      r_b1       <= i_bright;
      r_pix_en   <= r_hit1;
      r_h2       <= r_h1;
      r_v2       <= r_v1;
      r_b2       <= r_b1;
    end
  end

  // The ROM's own output register is the second pipeline stage; only the mask is added here.
  assign o_rom_addr     = r_rom_addr;
  assign o_pixel        = r_pix_en ? i_rom_data : '0;
  assign o_pix_en       = r_pix_en;
  assign o_hcount       = r_h2;
  assign o_vcount       = r_v2;
  assign o_bright       = r_b2;
  assign o_frame_commit = (r_state == COMMIT);
endmodule

// File: tb/tb_sprite_sched.sv
// Directed bench for sprite_sched: commit timing, priority, handshake, edge clipping, reset.
// Exercises the flip path too when SPRITE_HFLIP_EN is defined.
module tb_sprite_sched;
  localparam int DW = 24, NSPR = 4, SL = 5, AW = 4 + 2*SL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    hcount, vcount;
  logic          bright;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, pixel;
  logic          pix_en;
  logic [9:0]    hcount_o, vcount_o;
  logic          bright_o, frame_commit;
  int            n_checks = 0;
  int            n_errors = 0;

  sprite_sched_if #(.NSPR(NSPR)) u ();

  sprite_sched #(.DATA_WIDTH(DW), .NSPR(NSPR), .SPR_LOG2(SL)) dut (
    .clk(clk), .rst_n(rst_n), .i_hcount(hcount), .i_vcount(vcount), .i_bright(bright),
    .upd(u), .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_pixel(pixel),
    .o_pix_en(pix_en), .o_hcount(hcount_o), .o_vcount(vcount_o), .o_bright(bright_o),
    .o_frame_commit(frame_commit)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {10'h2A5, a};
  endfunction

  // Synchronous ROM model, one cycle of read latency.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raster(input int h, input int v, input logic b);
    hcount = 10'(h);
    vcount = 10'(v);
    bright = b;
  endtask

  task automatic write_slot(input int id, input int x, input int y, input int tile,
                            input logic en, input logic flip);
    int n;
    u.upd_valid = 1'b1;
    u.upd_id    = 2'(id);
    u.upd_x     = 10'(x);
    u.upd_y     = 10'(y);
    u.upd_tile  = 4'(tile);
    u.upd_en    = en;
`ifdef SPRITE_HFLIP_EN
    u.upd_flip  = flip;
`endif
    n = 0;
    while (u.upd_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (n == 8) check("wr_ready_timeout", 32'(u.upd_ready), 32'd1);
    tick();
    u.upd_valid = 1'b0;
    $display("write slot=%0d x=%0d y=%0d tile=%0d en=%0b flip=%0b", id, x, y, tile, en, flip);
  endtask

  task automatic do_commit(input string tag);
    set_raster(0, 480, 1'b0);
    tick();
    check({tag, "_pulse"}, 32'(frame_commit), 32'd1);
    check({tag, "_rdy0"}, 32'(u.upd_ready), 32'd0);
    set_raster(900, 600, 1'b0);
    tick();
    check({tag, "_pulse_end"}, 32'(frame_commit), 32'd0);
    $display("commit %s", tag);
  endtask

  // Address one cycle after the raster, outputs two cycles after; raster moves away in between.
  task automatic probe(input string tag, input int h, input int v, input logic b,
                       input logic [AW-1:0] exp_addr, input logic exp_en);
    logic [DW-1:0] exp_pix;
    set_raster(h, v, b);
    tick();
    check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    set_raster(900, 600, 1'b0);
    tick();
    exp_pix = exp_en ? rom_fn(exp_addr) : '0;
    check({tag, "_en"},  32'(pix_en),   32'(exp_en));
    check({tag, "_pix"}, 32'(pixel),    32'(exp_pix));
    check({tag, "_h"},   32'(hcount_o), 32'(h));
    check({tag, "_v"},   32'(vcount_o), 32'(v));
    check({tag, "_b"},   32'(bright_o), 32'(b));
    $display("probe %s h=%0d v=%0d addr=%0h pix_en=%0b pixel=%0h", tag, h, v, exp_addr, pix_en, pixel);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(rom_addr),     32'd0);
    check({tag, "_en"},    32'(pix_en),       32'd0);
    check({tag, "_pix"},   32'(pixel),        32'd0);
    check({tag, "_h"},     32'(hcount_o),     32'd0);
    check({tag, "_v"},     32'(vcount_o),     32'd0);
    check({tag, "_b"},     32'(bright_o),     32'd0);
    check({tag, "_fc"},    32'(frame_commit), 32'd0);
    check({tag, "_ready"}, 32'(u.upd_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u.upd_valid = 1'b0;
    u.upd_id    = '0;
    u.upd_x     = '0;
    u.upd_y     = '0;
    u.upd_tile  = '0;
    u.upd_en    = 1'b0;
`ifdef SPRITE_HFLIP_EN
    u.upd_flip  = 1'b0;
`endif
    rst_n = 1'b0;
    set_raster(5, 7, 1'b1);
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Staged before the first commit: nothing drawn yet.
    write_slot(0, 100, 50, 3, 1'b1, 1'b0);
    probe("wait_first", 100, 50, 1'b1, 14'h0000, 1'b0);
    do_commit("commit1");
    probe("s0_origin", 100, 50, 1'b1, 14'h0C00, 1'b1);
    probe("s0_corner", 131, 81, 1'b1, 14'h0FFF, 1'b1);
    probe("s0_right",  132, 50, 1'b1, 14'h0000, 1'b0);
    probe("s0_left",    99, 50, 1'b1, 14'h0000, 1'b0);
    probe("s0_dark",   110, 60, 1'b0, 14'h0D4A, 1'b0);

    // Overlap at (200,200): slot0 wins until it is disabled and committed.
    write_slot(1, 190, 190, 5, 1'b1, 1'b0);
    write_slot(0, 200, 200, 3, 1'b1, 1'b0);
    do_commit("commit2");
    probe("ovl_s0", 200, 200, 1'b1, 14'h0C00, 1'b1);
    write_slot(0, 200, 200, 3, 1'b0, 1'b0);
    probe("ovl_staged", 200, 200, 1'b1, 14'h0C00, 1'b1);
    do_commit("commit3");
    probe("ovl_s1", 200, 200, 1'b1, 14'h154A, 1'b1);

    // Update presented on the commit cycle must be held until ready returns.
    set_raster(0, 480, 1'b0);
    tick();
    u.upd_valid = 1'b1;
    u.upd_id    = 2'd2;
    u.upd_x     = 10'd300;
    u.upd_y     = 10'd300;
    u.upd_tile  = 4'd7;
    u.upd_en    = 1'b1;
    check("cc_ready", 32'(u.upd_ready), 32'd0);
    check("cc_pulse", 32'(frame_commit), 32'd1);
    set_raster(900, 600, 1'b0);
    tick();
    check("cc_hold_ready", 32'(u.upd_ready), 32'd1);
    tick();
    u.upd_valid = 1'b0;
    $display("write slot=2 held across commit");
    probe("cc_before", 300, 300, 1'b1, 14'h0000, 1'b0);
    do_commit("commit4");
    probe("cc_after", 300, 300, 1'b1, 14'h1C00, 1'b1);

    // Right-edge sprite: no wrap past 1023.
    write_slot(3, 1000, 10, 2, 1'b1, 1'b0);
    do_commit("commit5");
    probe("wrap_lo",  1000, 10, 1'b1, 14'h0800, 1'b1);
    probe("wrap_0",      0, 10, 1'b1, 14'h0000, 1'b0);
    probe("wrap_7",      7, 10, 1'b1, 14'h0000, 1'b0);
    probe("wrap_hi",  1023, 10, 1'b1, 14'h0817, 1'b1);

    // Reset while a sprite pixel is on the output.
    check("pre_rst_en", 32'(pix_en), 32'd1);
    set_raster(1010, 10, 1'b1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    probe("post_rst", 1010, 10, 1'b1, 14'h0000, 1'b0);
    write_slot(3, 1000, 10, 2, 1'b1, 1'b0);
    probe("post_rst_wait", 1010, 10, 1'b1, 14'h0000, 1'b0);

`ifdef SPRITE_HFLIP_EN
    write_slot(0, 100, 50, 3, 1'b1, 1'b1);
    do_commit("commit_flip");
    probe("flip_left",  100, 50, 1'b1, 14'h0C1F, 1'b1);
    probe("flip_right", 131, 50, 1'b1, 14'h0C00, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sprite_sched.md
SPRITE_SCHED -- requirements
Module: sprite_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 24, width of sprite ROM pixel data and of the pixel output.
REQ-002 Parameter NSPR, default 4, number of sprite slots; the upd_id width is $clog2(NSPR).
REQ-003 Parameter SPR_LOG2, default 5, sprite side length of 2**SPR_LOG2 pixels (32x32).
REQ-004 clk  input  1  single clock, pixel rate; all state on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 hcount, vcount  input  10 each  current raster position from VGA timing.
REQ-007 bright  input  1  visible-region flag from VGA timing.
REQ-008 upd_valid  input  1  sprite-update request.
REQ-009 upd_ready  output  1  update accepted when high with upd_valid.
REQ-010 upd_id  input  $clog2(NSPR)  target slot.
REQ-011 upd_x, upd_y  input  10 each  sprite top-left position.
REQ-012 upd_tile  input  4  tile index into sprite ROM.
REQ-013 upd_en  input  1  slot visible.
REQ-014 rom_addr  output  4+2*SPR_LOG2  {tile,row,col} to synchronous ROM (1-cycle read latency).
REQ-015 rom_data  input  DATA_WIDTH  ROM read data.
REQ-016 pixel  output  DATA_WIDTH  sprite pixel to bitgen.
REQ-017 pix_en  output  1  pixel valid to bitgen.
REQ-018 hcount_o, vcount_o  output  10 each; bright_o  output  1  raster signals delayed to align with pixel.
REQ-019 frame_commit  output  1  one-cycle pulse on the commit cycle.

Function
REQ-020 The block SHALL keep a staging set and an active set of {x,y,tile,en} per slot; updates write staging only.
REQ-021 An update SHALL be accepted on a cycle where upd_valid and upd_ready are both high; the later of two writes to one slot wins.
REQ-022 The FSM SHALL have states WAIT_FIRST, RUN and COMMIT.
REQ-023 Commit condition: vcount==480 and hcount==0; from WAIT_FIRST or RUN, the FSM SHALL enter COMMIT on the following cycle.
REQ-024 COMMIT SHALL last exactly one cycle: copy all staging to active, pulse frame_commit, drive upd_ready=0, then go to RUN.
REQ-025 upd_ready SHALL be 1 in every state except COMMIT; an upd_valid during COMMIT is not accepted and must be held by the requester.
REQ-026 In WAIT_FIRST, pix_en SHALL be 0 regardless of raster position.
REQ-027 Stage 0: slot i SHALL hit when en_i and hcount>=x_i and hcount-x_i<2**SPR_LOG2 and vcount>=y_i and vcount-y_i<2**SPR_LOG2, compared at 11 bits with no wrap-around past 1023.
REQ-028 With multiple hits, the lowest slot index SHALL win; with no hit, rom_addr SHALL be 0.
REQ-029 rom_addr SHALL be registered as {tile,vcount-y,hcount-x} of the winner (low SPR_LOG2 bits each).
REQ-030 Stage 2: pixel SHALL be registered rom_data, and pix_en SHALL be registered (hit AND bright, delayed 2).
REQ-031 Total latency from hcount/vcount/bright to pixel/pix_en/hcount_o/vcount_o/bright_o SHALL be exactly 2 cycles.
REQ-032 When pix_en=0, pixel SHALL be 0; transparency (pixel 0) is resolved downstream, not here.

Reset
REQ-033 With rst_n=0 at a clock edge, the block SHALL clear staging and active sets (en=0), enter WAIT_FIRST, and drive pixel, pix_en, rom_addr, hcount_o, vcount_o, bright_o and frame_commit to 0, with upd_ready=1 on the next cycle.
REQ-034 Reset mid-frame or mid-COMMIT SHALL discard pipeline contents; no partial commit survives.

Configuration
REQ-035 Macro SPRITE_HFLIP_EN: when defined, add input upd_flip (1 bit) stored per slot through staging/active; col SHALL be (2**SPR_LOG2-1)-(hcount-x) when flip set.
REQ-036 Without SPRITE_HFLIP_EN, the upd_flip port and state SHALL be absent, and col=hcount-x.

Verification
REQ-037 Reset, then write slot0 x=100 y=50 tile=3 en=1; check pix_en=0 until the first commit; in the next frame, hcount=100 vcount=50 -> rom_addr={3,0,0}, and 2 cycles later pix_en=1 with pixel=rom_data.
REQ-038 Slots 0 and 1 overlap at (200,200): rom_addr uses slot0's tile; disable slot0 -> after the next commit, slot1's tile is used.
REQ-039 Update asserted on the commit cycle: upd_ready=0, write not taken; held one more cycle -> accepted; visible only after the following commit.
REQ-040 Sprite x=1000: hcount 1000..1023 hit, hcount 0..7 no hit (no wrap); at hcount=1032-equivalent edge, col=31 at hcount=1031 is never reached.
REQ-041 rst_n=0 mid-line with pix_en=1 -> next cycle all outputs 0, state WAIT_FIRST, previously active sprites not drawn.
REQ-042 With SPRITE_HFLIP_EN, flip=1 and x=100: hcount=100 -> col=31; hcount=131 -> col=0.
